load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 12 +
 rtl/defines.vh | 9 +
 rtl/load_store_unit_lane_align.sv | 25 ++
 rtl/load_store_unit.sv | 100 ++++++++++
 tb/tb_load_store_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: datapath widths, size codes and the alignment check
package load_store_unit_pkg;
`include "defines.vh"
  localparam int DW = 8 * `WORD_SIZE_B;
  localparam int AW = $clog2(`RAM_CAPACITY);
  localparam logic [1:0] SIZE_B = `LSU_SIZE_B;
  localparam logic [1:0] SIZE_H = `LSU_SIZE_H;
  localparam logic [1:0] SIZE_W = `LSU_SIZE_W;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_H ? off[0] : size == SIZE_W ? off != 2'b00 : size != SIZE_B;
  endfunction
endpackage

// File: rtl/defines.vh
// defines.vh: word size, RAM capacity and access-size codes shared across the LSU
`ifndef LSU_DEFINES_VH
`define LSU_DEFINES_VH
`define WORD_SIZE_B 4
`define RAM_CAPACITY 1024
`define LSU_SIZE_B 2'b00
`define LSU_SIZE_H 2'b01
`define LSU_SIZE_W 2'b10
`endif

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [1:0]    off,
  input  logic [DW-1:0] rword,
  input  logic [15:0]   wdata,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] mword
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rword[{off, 3'b000} +: 8];
  assign h = rword[{off[1], 4'b0000} +: 16];
  assign ldata = size == SIZE_B ? {{(DW-8){sign_ext & b[7]}}, b}
               : size == SIZE_H ? {{(DW-16){sign_ext & h[15]}}, h} : rword;
  // overwrite only the addressed lanes of the word just read
  always_comb begin
    mword = rword;
    if (size == SIZE_B) mword[{off, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_H) mword[{off[1], 4'b0000} +: 16] = wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-port RAM load/store sequencer with RMW sub-word stores (optional LSU_TIMEOUT_EN)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req,
  input  logic          Store,
  input  logic [1:0]    Size,
  input  logic          Sign_ext,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] Wdata,
  output logic [DW-1:0] Rdata,
  output logic          Done,
  output logic          Err,
  output logic          Busy,
  output logic [AW-1:0] Mem_addr,
  output logic          Mem_cs,
  output logic          Mem_we,
  output logic [DW-1:0] Mem_wdata,
  input  logic [DW-1:0] Mem_rdata,
  input  logic          Mem_ack
);
  typedef enum logic [2:0] {IDLE, RD, GAP, WR, DONE, ERR} state_t;
  state_t state;
  logic st, sx, to;
  logic [1:0] sz, off;
  logic [DW-1:0] wd, ldata, mword;
  lsu_lane_align u_align (
    .size(sz), .sign_ext(sx), .off(off), .rword(Mem_rdata), .wdata(wd[15:0]),
    .ldata(ldata), .mword(mword)
  );
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  assign to = (state == RD || state == WR) && !Mem_ack && cnt == TMAX;
  // count cycles spent waiting for an acknowledge in the current RAM access
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) cnt <= '0;
    else cnt <= (state == RD || state == WR) && !Mem_ack ? cnt + 1'b1 : '0;
`else
  assign to = 1'b0;
`endif
  // sequencer with registered RAM and core-side outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      {st, sx, sz, off, wd} <= '0;
      {Rdata, Done, Err, Busy, Mem_addr, Mem_cs, Mem_we, Mem_wdata} <= '0;
    end else begin
      case (state)
        IDLE: if (Req) begin
          {st, sz, sx, off, wd} <= {Store, Size, Sign_ext, Addr[1:0], Wdata};
          Busy <= 1'b1;
          Mem_addr <= {Addr[AW-1:2], 2'b00};
          Mem_wdata <= Wdata;
          if (misaligned(Size, Addr[1:0])) begin
            {Done, Err} <= 2'b11;
            state <= ERR;
          end else begin
            Mem_cs <= 1'b1;
            Mem_we <= Store && Size == SIZE_W;
            state <= Store && Size == SIZE_W ? WR : RD;
          end
        end
        RD: if (to) begin
          Mem_cs <= 1'b0;
          {Done, Err} <= 2'b11;
          state <= ERR;
        end else if (Mem_ack) begin
          Mem_cs <= 1'b0;
          if (st) begin
            Mem_wdata <= mword;
            state <= GAP;
          end else begin
            Rdata <= ldata;
            Done <= 1'b1;
            state <= DONE;
          end
        end
        GAP: begin
          {Mem_cs, Mem_we} <= 2'b11;
          state <= WR;
        end
        WR: if (to || Mem_ack) begin
          {Mem_cs, Mem_we} <= 2'b00;
          {Done, Err} <= {1'b1, to};
          state <= to ? ERR : DONE;
        end
        default: begin
          {Done, Err, Busy} <= 3'b000;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit against a one-cycle-ack RAM model
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, store = 1'b0, sign_ext = 1'b0;
  logic [1:0] size = 2'b00;
  logic [AW-1:0] addr = '0, mem_addr;
  logic [DW-1:0] wdata = '0, rdata, mem_wdata, mem_rdata;
  logic done, err, busy, mem_cs, mem_we, mem_ack, hold = 1'b0;
  logic [DW-1:0] mem [0:255];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {
    logic st; logic [1:0] sz; logic sx; logic [AW-1:0] a; logic [DW-1:0] wd;
    logic [DW-1:0] rd; logic er; int txn;
  } vec_t;
  vec_t v [15];

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .Store(store), .Size(size), .Sign_ext(sign_ext),
    .Addr(addr), .Wdata(wdata), .Rdata(rdata), .Done(done), .Err(err), .Busy(busy),
    .Mem_addr(mem_addr), .Mem_cs(mem_cs), .Mem_we(mem_we), .Mem_wdata(mem_wdata),
    .Mem_rdata(mem_rdata), .Mem_ack(mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (rst) begin
      mem[1] <= 32'haabbccdd;
      mem[2] <= 32'h11223344;
    end else if (mem_cs && !mem_ack && !hold) begin
      mem_ack <= 1'b1;
      mem_rdata <= mem[mem_addr[AW-1:2]];
      if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    @(negedge clk);
    {req, store, size, sign_ext, addr, wdata} = {1'b1, st, sz, sx, a, wd};
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic run_op(input string tag, input vec_t t);
    int acc, txn, last_ack, dcyc;
    logic pc, got;
    issue(t.st, t.sz, t.sx, t.a, t.wd);
    acc = cyc - 1;
    chk({tag, " busy"}, busy, 1);
    {pc, got, txn, last_ack, dcyc} = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_cs && !pc) txn++;
      pc = mem_cs;
      if (mem_cs && mem_ack) last_ack = cyc;
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    chk({tag, " done"}, got, 1);
    chk({tag, " err"}, err, t.er);
    chk({tag, " rdata"}, rdata, t.rd);
    chk({tag, " txn"}, txn, t.txn);
    chk({tag, " latency"}, dcyc - (t.txn > 0 ? last_ack : acc), 1);
    @(negedge clk);
    chk({tag, " pulse"}, {done, busy}, 0);
  endtask

  initial begin
    v[0]  = '{1'b1, 2'b10, 1'b0, 10'h000, 32'hdeadbeef, 32'h00000000, 1'b0, 1};
    v[1]  = '{1'b0, 2'b10, 1'b0, 10'h000, 32'h0,        32'hdeadbeef, 1'b0, 1};
    v[2]  = '{1'b0, 2'b00, 1'b1, 10'h006, 32'h0,        32'hffffffbb, 1'b0, 1};
    v[3]  = '{1'b0, 2'b00, 1'b0, 10'h006, 32'h0,        32'h000000bb, 1'b0, 1};
    v[4]  = '{1'b1, 2'b01, 1'b0, 10'h00a, 32'h0000beef, 32'h000000bb, 1'b0, 2};
    v[5]  = '{1'b0, 2'b10, 1'b0, 10'h008, 32'h0,        32'hbeef3344, 1'b0, 1};
    v[6]  = '{1'b0, 2'b10, 1'b0, 10'h005, 32'h0,        32'hbeef3344, 1'b1, 0};
    v[7]  = '{1'b0, 2'b01, 1'b1, 10'h004, 32'h0,        32'hffffccdd, 1'b0, 1};
    v[8]  = '{1'b0, 2'b01, 1'b0, 10'h006, 32'h0,        32'h0000aabb, 1'b0, 1};
    v[9]  = '{1'b1, 2'b00, 1'b0, 10'h007, 32'hffffff5a, 32'h0000aabb, 1'b0, 2};
    v[10] = '{1'b0, 2'b10, 1'b0, 10'h004, 32'h0,        32'h5abbccdd, 1'b0, 1};
    v[11] = '{1'b0, 2'b11, 1'b0, 10'h000, 32'h0,        32'h5abbccdd, 1'b1, 0};
    v[12] = '{1'b0, 2'b01, 1'b0, 10'h003, 32'h0,        32'h5abbccdd, 1'b1, 0};
    v[13] = '{1'b0, 2'b00, 1'b1, 10'h005, 32'h0,        32'hffffffcc, 1'b0, 1};
    v[14] = '{1'b1, 2'b10, 1'b0, 10'h002, 32'h12345678, 32'hffffffcc, 1'b1, 0};
    repeat (3) @(negedge clk);
    chk("reset outputs", {rdata, done, err, busy, mem_addr, mem_cs, mem_we, mem_wdata}, 0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) run_op($sformatf("v%0d", i), v[i]);
    hold = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
`ifdef LSU_TIMEOUT_EN
    begin
      int cs_cyc;
      logic got;
      {cs_cyc, got} = '0;
      for (int i = 0; i < 40 && !got; i++) begin
        if (i > 0) @(negedge clk);
        if (mem_cs) cs_cyc++;
        got = done;
      end
      chk("timeout cs cycles", cs_cyc, 16);
      chk("timeout done/err/cs", {got, err, mem_cs}, 3'b110);
      @(negedge clk);
      chk("timeout pulse", {done, err, busy}, 0);
    end
`else
    repeat (40) @(negedge clk);
    chk("no timeout busy/cs", {busy, mem_cs, done}, 3'b110);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("late ack load", rdata, 32'hdeadbeef);
`endif
    hold = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
    @(negedge clk);
    chk("mid-rd cs/busy", {mem_cs, busy}, 2'b11);
    #1 rst = 1'b1;
    #1 chk("async reset", {mem_cs, busy, rdata, mem_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        seen |= done;
      end
      chk("no done after reset", seen, 0);
    end
    run_op("post-reset", '{1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 32'hdeadbeef, 1'b0, 1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
